// File: rtl/wfg_drive_pwm.sv
// -----------------------------------------------------------------------------
// wfg_drive_pwm
//
// AXI-stream sink that turns a stream of 18-bit signed samples into a PWM
// waveform, one sample per PWM period (1-bit DAC driver). The next sample is
// prefetched while the current period runs. A period that ends without a
// prefetched sample repeats the previous duty and raises an underrun pulse.
//
// Optional build macro:
//   WFG_DRIVE_PWM_DEADTIME_EN - adds complementary output pwm_n_o with a
//                               programmable dead time (deadtime_q_i).
//
// Parameters:
//   PERIOD_MIN         lower clamp for period_q_i (in clk cycles)
//
// Ports:
//   clk                clock
//   rst                asynchronous reset, active-high
//   ctrl_en_q_i        block enable; low returns to idle and drops buffered data
//   period_q_i         PWM period in clk cycles (sampled at period boundaries)
//   deadtime_q_i       dead time in clk cycles        (WFG_DRIVE_PWM_DEADTIME_EN)
//   pwm_n_o            complementary PWM output       (WFG_DRIVE_PWM_DEADTIME_EN)
//   wfg_axis_tready_o  AXI-stream ready
//   wfg_axis_tvalid_i  AXI-stream valid
//   wfg_axis_tdata_i   AXI-stream data, signed sample
//   pwm_o              PWM output
//   period_start_o     pulse in the first cycle of every running period
//   underrun_o         pulse in the last cycle of a period with no next sample
// -----------------------------------------------------------------------------
module wfg_drive_pwm #(
   parameter int unsigned PERIOD_MIN = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ctrl_en_q_i,
   input  logic [15:0] period_q_i,
`ifdef WFG_DRIVE_PWM_DEADTIME_EN
   input  logic [7:0]  deadtime_q_i,
   output logic        pwm_n_o,
`endif
   output logic        wfg_axis_tready_o,
   input  logic        wfg_axis_tvalid_i,
   input  logic [17:0] wfg_axis_tdata_i,
   output logic        pwm_o,
   output logic        period_start_o,
   output logic        underrun_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_RUN
   } state_t;

   localparam logic [15:0] P_MIN = 16'(PERIOD_MIN);

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] period_l_q, period_l_d;
   logic [15:0] duty_l_q, duty_l_d;
   logic [17:0] sample_q, sample_d;
   logic        pending_q, pending_d;

   logic [15:0] p_eff;
   logic [17:0] duty_src;
   logic [15:0] duty_calc;
   logic        in_run;
   logic        boundary;
   logic        handshake;
   logic        raw_pwm;

   assign p_eff    = (period_q_i < P_MIN) ? P_MIN : period_q_i;
   assign in_run   = (state_q == ST_RUN);
   assign boundary = in_run && (cnt_q == period_l_q - 16'd1);

   // Enable gates ready combinationally so no beat is accepted in the cycle
   // the block is being shut down.
   assign wfg_axis_tready_o = ctrl_en_q_i &&
                              ((state_q == ST_FETCH) || (in_run && !pending_q));
   assign handshake = wfg_axis_tvalid_i && wfg_axis_tready_o;

   // A beat accepted in the boundary cycle itself feeds the next period
   // directly from the bus; otherwise the buffered sample is used.
   assign duty_src = (in_run && !pending_q) ? wfg_axis_tdata_i : sample_q;

   // Flipping the sign bit maps the signed sample onto offset binary, so the
   // most negative sample gives duty 0 and the most positive gives P-1.
   assign duty_calc = 16'((34'({~duty_src[17], duty_src[16:0]}) * 34'(p_eff)) >> 18);

   assign raw_pwm        = in_run && (cnt_q < duty_l_q);
   assign period_start_o = in_run && (cnt_q == 16'd0);
   assign underrun_o     = boundary && ctrl_en_q_i && !pending_q && !handshake;

   // NOTE: every state element is written with <= so all registers update
   // from the same pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         period_l_q <= '0;
         duty_l_q   <= '0;
         sample_q   <= '0;
         pending_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         period_l_q <= period_l_d;
         duty_l_q   <= duty_l_d;
         sample_q   <= sample_d;
         pending_q  <= pending_d;
      end
   end

   always_comb begin
      // NOTE: every signal gets a hold-value default first, so no path through
      // the case statement can leave one unassigned and infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      period_l_d = period_l_q;
      duty_l_d   = duty_l_q;
      sample_d   = sample_q;
      pending_d  = pending_q;

      if (!ctrl_en_q_i) begin
         state_d   = ST_IDLE;
         pending_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: state_d = ST_FETCH;

            ST_FETCH: begin
               if (handshake) begin
                  sample_d = wfg_axis_tdata_i;
                  state_d  = ST_LOAD;
               end
            end

            ST_LOAD: begin
               period_l_d = p_eff;
               duty_l_d   = duty_calc;
               cnt_d      = '0;
               state_d    = ST_RUN;
            end

            ST_RUN: begin
               if (boundary) begin
                  cnt_d      = '0;
                  period_l_d = p_eff;
                  // Without a new sample the previous duty is repeated as is.
                  if (pending_q || handshake) begin
                     duty_l_d  = duty_calc;
                     pending_d = 1'b0;
                  end
               end else begin
                  cnt_d = cnt_q + 16'd1;
                  if (handshake) begin
                     sample_d  = wfg_axis_tdata_i;
                     pending_d = 1'b1;
                  end
               end
            end

            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef WFG_DRIVE_PWM_DEADTIME_EN
   // hi_len_q / lo_len_q count how many cycles the raw high / low phase has
   // already lasted (saturating). An output turns on only once its phase is
   // at least deadtime_q_i cycles old, so both edges leading into an output
   // are delayed while trailing edges stay immediate. The two outputs can
   // therefore never overlap.
   logic [7:0] hi_len_q;
   logic [7:0] lo_len_q;
   logic       raw_pwm_n;

   assign raw_pwm_n = in_run && !raw_pwm;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_len_q <= '0;
         lo_len_q <= '0;
      end else begin
         hi_len_q <= !raw_pwm          ? 8'd0 :
                     (hi_len_q == 8'hFF) ? hi_len_q : hi_len_q + 8'd1;
         lo_len_q <= !raw_pwm_n        ? 8'd0 :
                     (lo_len_q == 8'hFF) ? lo_len_q : lo_len_q + 8'd1;
      end
   end

   assign pwm_o   = raw_pwm   && (hi_len_q >= deadtime_q_i);
   assign pwm_n_o = raw_pwm_n && (lo_len_q >= deadtime_q_i);
`else
   assign pwm_o = raw_pwm;
`endif

endmodule
